debounced_button_counter: RTL and testbench
===========================================

// Module: debounced_button_counter
// PURPOSE
//  Multi-channel successor to the single-button press counter: each channel synchronises a raw
//  button pin, debounces both press and release edges, and counts debounced presses.
//  Sits between board push-buttons and the UART/display logic; exposes per-channel counts,
//  one-cycle press pulses and a debounced level. Adds release debounce, polarity, wrap/saturate, clear.
// PARAMETERS
//  CHANNELS         4        number of independent button channels (>=1)
//  CNT_WIDTH        8        width of each press counter
//  DEBOUNCE_CYCLES  5000000  consecutive stable-level cycles required to accept a transition (>=2)
//  ACTIVE_LOW       1        1: pin==0 means pressed; 0: pin==1 means pressed
//  SATURATE         0        0: counter wraps max->0; 1: counter holds at max
// PORTS
//  clk          in   1                   system clock
//  rst          in   1                   asynchronous, active-high reset
//  button_pin   in   CHANNELS            raw asynchronous button inputs
//  clear        in   1                   synchronous clear of all counters
//  value        out  CHANNELS*CNT_WIDTH  press counts; channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//  press_pulse  out  CHANNELS            1-cycle strobe per accepted press
//  pressed      out  CHANNELS            debounced button level (1 = held)
// BEHAVIOUR
//  - Reset (async, rst=1): all FSMs IDLE, timers 0, sync flops = released level, value=0,
//    press_pulse=0, pressed=0. Effective immediately, mid-debounce included; no count on release.
//  - Per channel: 2-flop synchroniser, then polarity normalise -> act (1 = pressed). Timer width
//    $clog2(DEBOUNCE_CYCLES).
//  - FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
//    IDLE:         act=1 -> PRESS_WAIT, timer=0.
//    PRESS_WAIT:   act=0 -> IDLE (glitch rejected, timer=0); act=1 and timer==DEBOUNCE_CYCLES-1
//                  -> HELD, press_pulse=1 next cycle, counter increments; else timer++.
//    HELD:         act=0 -> RELEASE_WAIT, timer=0.
//    RELEASE_WAIT: act=1 -> HELD (no new count); act=0 and timer==DEBOUNCE_CYCLES-1 -> IDLE;
//                  else timer++.
//  - pressed=1 exactly in HELD and RELEASE_WAIT. Registered output.
//  - Latency: raw pin edge -> press_pulse = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
//    value shows the new count in the same cycle press_pulse is high.
//  - Exactly one count per debounced press, however long the hold or bouncy the release.
//  - Counter arithmetic CNT_WIDTH bits unsigned. SATURATE=0: 2^CNT_WIDTH-1 +1 -> 0.
//    SATURATE=1: stays 2^CNT_WIDTH-1; press_pulse still fires.
//  - clear=1: all counters -> 0 next cycle; FSMs/timers unaffected. Clear and increment in the
//    same cycle: clear wins (value=0), press_pulse still asserted.
//  - Channels fully independent; simultaneous presses on several channels each counted.
// STRUCTURE
//  - Package debounced_button_pkg: channel state typedef (2-bit enum IDLE/PRESS_WAIT/HELD/
//    RELEASE_WAIT), SYNC_STAGES=2 constant.
//  - Sub-module button_debounce_channel (sync + FSM + timer -> pressed, press_pulse);
//    top instantiates CHANNELS copies in a generate loop and owns the counters and clear logic.
// TESTING (bench uses DEBOUNCE_CYCLES=4, CNT_WIDTH=3, CHANNELS=2, ACTIVE_LOW=1)
//  - Clean press ch0: pin 1->0 held 20 cycles -> press_pulse[0] once, 7 cycles after the edge;
//    value ch0=1; pressed[0]=1 until release is accepted.
//  - Bounce: pin low 3 cycles, high 1, low 10 -> exactly one pulse; value=1; first burst rejected.
//  - Release bounce: while held, pin high 2 cycles then low again -> pressed stays 1, no extra count.
//  - Wrap: 9 clean presses, SATURATE=0 -> value 1..7,0,1. Rerun with SATURATE=1 -> stays 7,
//    9 pulses seen.
//  - Clear collides with 3rd press strobe -> value=0 that cycle onward; next press -> 1;
//    ch1 unaffected by ch0 activity.
//  - rst asserted mid PRESS_WAIT, pin held low -> outputs 0 asynchronously; after release of rst,
//    a fresh full debounce is required before the count becomes 1.

Source files
------------

// File: rtl/debounced_button_pkg.sv
// Shared types and constants for the debounced multi-channel button counter.
package debounced_button_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } chan_state_t;

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: synchroniser, polarity normalisation and press/release debounce FSM.
module button_debounce_channel
    import debounced_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 5000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic pressed,
    output logic press_pulse,
    output logic press_accept
);

    localparam int TIMER_W = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   act;
    chan_state_t            state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;

    // Synchroniser resets to the released pin level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{POL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    assign act = sync_q[SYNC_STAGES-1] ^ POL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            pressed     <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pressed     <= (state_d == HELD) || (state_d == RELEASE_WAIT);
            press_pulse <= press_accept;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        press_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (act) begin
                    state_d = PRESS_WAIT;
                    timer_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!act) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d      = HELD;
                    timer_d      = '0;
                    press_accept = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HELD: begin
                if (!act) begin
                    state_d = RELEASE_WAIT;
                    timer_d = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to pressed returns to HELD without producing a new count.
                if (act) begin
                    state_d = HELD;
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

endmodule

// File: rtl/debounced_button_counter.sv
// Multi-channel debounced button press counter with wrap/saturate counters and a global clear.
module debounced_button_counter
    import debounced_button_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int CNT_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 5000000,
    parameter int ACTIVE_LOW      = 1,
    parameter int SATURATE        = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           button_pin,
    input  logic                          clear,
    output logic [CHANNELS*CNT_WIDTH-1:0] value,
    output logic [CHANNELS-1:0]           press_pulse,
    output logic [CHANNELS-1:0]           pressed
);

    logic [CHANNELS-1:0]  press_accept;
    logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];

    function automatic logic [CNT_WIDTH-1:0] bump_count(input logic [CNT_WIDTH-1:0] cnt);
        if ((SATURATE != 0) && (cnt == {CNT_WIDTH{1'b1}})) begin
            return cnt;
        end
        return cnt + 1'b1;
    endfunction

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        button_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .pin          (button_pin[g]),
            .pressed      (pressed[g]),
            .press_pulse  (press_pulse[g]),
            .press_accept (press_accept[g])
        );

        // Counter updates on the accept edge so value and press_pulse appear together.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q[g] <= '0;
            end else if (clear) begin
                cnt_q[g] <= '0;
            end else if (press_accept[g]) begin
                cnt_q[g] <= bump_count(cnt_q[g]);
            end
        end
    end

    always_comb begin
        value = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            value[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_debounced_button_counter.sv
// Scoreboard bench: a run-length debounce model predicts presses; a monitor checks both DUT variants.
module tb_debounced_button_counter;

    localparam int CH = 2;
    localparam int W  = 3;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] button_pin;
    logic          clear;
    logic [CH*W-1:0] value_w, value_s;
    logic [CH-1:0]   press_pulse_w, press_pulse_s, pressed_w, pressed_s;

    always #5 clk = ~clk;

    debounced_button_counter #(
        .CHANNELS(CH), .CNT_WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1), .SATURATE(0)
    ) dut_w (
        .clk(clk), .rst(rst), .button_pin(button_pin), .clear(clear),
        .value(value_w), .press_pulse(press_pulse_w), .pressed(pressed_w)
    );

    debounced_button_counter #(
        .CHANNELS(CH), .CNT_WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1), .SATURATE(1)
    ) dut_s (
        .clk(clk), .rst(rst), .button_pin(button_pin), .clear(clear),
        .value(value_s), .press_pulse(press_pulse_s), .pressed(pressed_s)
    );

    typedef struct {
        int ch;
        int cyc;
        int vw;
        int vs;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // Reference model: a new level is accepted after D+1 consecutive synchronised samples differ.
    logic [CH-1:0] h1, h2, lvl;
    int            run   [CH];
    int            cnt_w [CH];
    int            cnt_s [CH];
    int            pulses_s   [CH];
    int            last_pulse [CH];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            h1  = '1;
            h2  = '1;
            lvl = '0;
            for (int ch = 0; ch < CH; ch++) begin
                run[ch]   = 0;
                cnt_w[ch] = 0;
                cnt_s[ch] = 0;
            end
        end else begin
            for (int ch = 0; ch < CH; ch++) begin
                logic act;
                logic acc;
                act = ~h2[ch];
                acc = 1'b0;
                if (act != lvl[ch]) begin
                    run[ch] = run[ch] + 1;
                    if (run[ch] == D + 1) begin
                        lvl[ch] = act;
                        run[ch] = 0;
                        acc     = act;
                    end
                end else begin
                    run[ch] = 0;
                end
                if (clear) begin
                    cnt_w[ch] = 0;
                    cnt_s[ch] = 0;
                end else if (acc) begin
                    cnt_w[ch] = (cnt_w[ch] + 1) % (1 << W);
                    cnt_s[ch] = (cnt_s[ch] == (1 << W) - 1) ? cnt_s[ch] : cnt_s[ch] + 1;
                end
                if (acc) sb.push_back('{ch, cyc, cnt_w[ch], cnt_s[ch]});
            end
            h2 = h1;
            h1 = button_pin;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [CH-1:0]   exp_mask;
            int              exp_vw [CH];
            int              exp_vs [CH];
            logic [CH*W-1:0] mdl_vw, mdl_vs;
            exp_t            e;
            exp_mask = '0;
            for (int ch = 0; ch < CH; ch++) begin
                exp_vw[ch] = 0;
                exp_vs[ch] = 0;
                mdl_vw[ch*W +: W] = W'(cnt_w[ch]);
                mdl_vs[ch*W +: W] = W'(cnt_s[ch]);
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                chk("pulse_cycle", e.cyc, cyc);
                exp_mask[e.ch] = 1'b1;
                exp_vw[e.ch]   = e.vw;
                exp_vs[e.ch]   = e.vs;
            end
            if (press_pulse_w != '0 || press_pulse_s != '0 || exp_mask != '0) begin
                chk("pulse_w", int'(press_pulse_w), int'(exp_mask));
                chk("pulse_s", int'(press_pulse_s), int'(exp_mask));
                for (int ch = 0; ch < CH; ch++) begin
                    if (exp_mask[ch]) begin
                        chk("pulse_value_w", int'(value_w[ch*W +: W]), exp_vw[ch]);
                        chk("pulse_value_s", int'(value_s[ch*W +: W]), exp_vs[ch]);
                    end
                    if (press_pulse_s[ch]) begin
                        pulses_s[ch]++;
                        last_pulse[ch] = cyc;
                    end
                end
            end
            chk("pressed_w", int'(pressed_w), int'(lvl));
            chk("pressed_s", int'(pressed_s), int'(lvl));
            chk("value_w", int'(value_w), int'(mdl_vw));
            chk("value_s", int'(value_s), int'(mdl_vs));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(input int ch, input int lo, input int hi);
        button_pin[ch] = 1'b0;
        tick(lo);
        button_pin[ch] = 1'b1;
        tick(hi);
    endtask

    initial begin
        int c0, c2, p0, v1;
        int rem [CH];
        for (int ch = 0; ch < CH; ch++) begin
            pulses_s[ch]   = 0;
            last_pulse[ch] = -1;
            rem[ch]        = 0;
        end
        rst        = 1'b1;
        button_pin = '1;
        clear      = 1'b0;
        tick(3);
        chk("reset_value", int'(value_w), 0);
        chk("reset_pressed", int'(pressed_w), 0);
        chk("reset_pulse", int'(press_pulse_w), 0);
        rst = 1'b0;
        tick(3);

        // Clean press on ch0: pulse seven cycles after the pin edge.
        c0 = cyc;
        p0 = pulses_s[0];
        button_pin[0] = 1'b0;
        tick(20);
        chk("clean_latency", last_pulse[0], c0 + 7);
        chk("clean_pulses", pulses_s[0] - p0, 1);
        chk("clean_value", int'(value_w[W-1:0]), 1);
        chk("clean_pressed", int'(pressed_w[0]), 1);
        c0 = cyc;
        button_pin[0] = 1'b1;
        tick(6);
        chk("release_not_yet", int'(pressed_w[0]), 1);
        tick(2);
        chk("release_done", int'(pressed_w[0]), 0);
        tick(4);

        // Press bounce: first short burst rejected.
        p0 = pulses_s[0];
        press(0, 3, 1);
        press(0, 10, 12);
        chk("bounce_pulses", pulses_s[0] - p0, 1);
        chk("bounce_value", int'(value_w[W-1:0]), 2);

        // Release bounce while held.
        p0 = pulses_s[0];
        button_pin[0] = 1'b0;
        tick(12);
        button_pin[0] = 1'b1;
        tick(2);
        button_pin[0] = 1'b0;
        tick(8);
        chk("relbounce_pressed", int'(pressed_w[0]), 1);
        chk("relbounce_pulses", pulses_s[0] - p0, 1);
        button_pin[0] = 1'b1;
        tick(12);

        // Wrap versus saturate over nine presses.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        p0 = pulses_s[0];
        for (int i = 1; i <= 9; i++) begin
            press(0, 8, 8);
            chk("wrap_value", int'(value_w[W-1:0]), i % 8);
            chk("sat_value", int'(value_s[W-1:0]), (i > 7) ? 7 : i);
        end
        chk("sat_pulses", pulses_s[0] - p0, 9);

        // Clear colliding with the third press strobe; ch1 independent.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        press(1, 8, 8);
        v1 = int'(value_w[2*W-1:W]);
        chk("ch1_count", v1, 1);
        press(0, 8, 8);
        press(0, 8, 8);
        c0 = cyc;
        button_pin[0] = 1'b0;
        tick(6);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clear_collide_value", int'(value_w[W-1:0]), 0);
        chk("clear_collide_pulse", last_pulse[0], c0 + 7);
        tick(4);
        button_pin[0] = 1'b1;
        tick(10);
        press(0, 8, 8);
        chk("after_clear_value", int'(value_w[W-1:0]), 1);
        chk("ch1_after_clear", int'(value_w[2*W-1:W]), 0);
        press(0, 8, 8);
        chk("ch1_unaffected", int'(value_w[2*W-1:W]), 0);

        // Reset in the middle of a press debounce with the pin held low.
        button_pin[0] = 1'b0;
        tick(4);
        #1 rst = 1'b1;
        #1;
        chk("rst_value_w", int'(value_w), 0);
        chk("rst_value_s", int'(value_s), 0);
        chk("rst_pressed", int'(pressed_w), 0);
        chk("rst_pulse", int'(press_pulse_w), 0);
        tick(2);
        #1 rst = 1'b0;
        c2 = cyc;
        tick(12);
        chk("rst_fresh_latency", last_pulse[0], c2 + 7);
        chk("rst_fresh_value", int'(value_w[W-1:0]), 1);
        button_pin[0] = 1'b1;
        tick(10);

        // Randomised bouncing on both channels with occasional clears.
        for (int n = 0; n < 800; n++) begin
            for (int ch = 0; ch < CH; ch++) begin
                if (rem[ch] == 0) begin
                    button_pin[ch] = ~button_pin[ch];
                    rem[ch] = int'($urandom_range(1, 9));
                end
                rem[ch]--;
            end
            clear = ($urandom_range(0, 39) == 0);
            tick(1);
        end
        clear      = 1'b0;
        button_pin = '1;
        tick(20);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
